// File: rtl/real_pkg.sv
// Shared encodings and rounding helpers for the real_round packing stage.
package real_pkg;

  typedef enum logic [1:0] {
    RM_RNE = 2'b00,
    RM_RTZ = 2'b01,
    RM_RUP = 2'b10,
    RM_RDN = 2'b11
  } rm_e;

  typedef enum logic [1:0] {
    CLS_FIN  = 2'b00,
    CLS_ZERO = 2'b01,
    CLS_INF  = 2'b10,
    CLS_NAN  = 2'b11
  } cls_e;

  localparam int unsigned FLG_OVF = 2;
  localparam int unsigned FLG_UNF = 1;
  localparam int unsigned FLG_INX = 0;

  // Increment decision from the LSB / guard / sticky bits for each mode.
  function automatic logic round_inc(input rm_e rm, input logic sign,
                                     input logic lsb, input logic g, input logic s);
    logic inc;
    case (rm)
      RM_RNE:  inc = g & (s | lsb);
      RM_RTZ:  inc = 1'b0;
      RM_RUP:  inc = ~sign & (g | s);
      default: inc = sign & (g | s);
    endcase
    return inc;
  endfunction

  // Whether an overflow saturates to infinity (1) or to max finite (0).
  function automatic logic ovf_to_inf(input rm_e rm, input logic sign);
    logic inf;
    case (rm)
      RM_RNE:  inf = 1'b1;
      RM_RTZ:  inf = 1'b0;
      RM_RUP:  inf = ~sign;
      default: inf = sign;
    endcase
    return inf;
  endfunction

endpackage

// File: rtl/rshift_sticky.sv
// Combinational right shifter that also reports whether any set bit fell off the end.
module rshift_sticky #(
  parameter int unsigned W    = 56,
  parameter int unsigned SH_W = 6
) (
  input  logic [W-1:0]    in_i,
  input  logic [SH_W-1:0] sh_i,
  output logic [W-1:0]    out_o,
  output logic            sticky_o
);

  logic [W-1:0] lost_mask;

  // Shift and OR together the bits that were discarded.
  always_comb begin
    out_o     = in_i >> sh_i;
    lost_mask = ~({W{1'b1}} << sh_i);
    sticky_o  = |(in_i & lost_mask);
  end

endmodule

// File: rtl/real_round.sv
// Rounding and IEEE754 packing stage: denormal shift + round decision, then add/pack/flags.
module real_round
  import real_pkg::*;
#(
  parameter int unsigned EXP_W      = 11,
  parameter int unsigned MANT_RAW_W = 53,
  parameter int unsigned WIDTH      = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_sign,
  input  logic [EXP_W+1:0]      in_exp,
  input  logic [MANT_RAW_W+2:0] in_mant,
  input  logic [1:0]            in_class,
  input  logic [1:0]            rm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      res,
  output logic [2:0]            flags
);

  localparam int unsigned MANT_W = MANT_RAW_W - 1;
  localparam int unsigned MW     = MANT_RAW_W + 3;
  localparam int unsigned SH_W   = $clog2(MW);
  localparam int unsigned AMT_W  = EXP_W + 3;

  localparam logic [EXP_W-1:0]  EXP_ONES   = '1;
  localparam logic [EXP_W-1:0]  EXP_MAXF   = EXP_ONES - EXP_W'(1);
  localparam logic [MANT_W-1:0] QNAN_FRAC  = MANT_W'(1) << (MANT_W - 1);
  localparam logic [AMT_W-1:0]  SH_SAT     = AMT_W'(MW - 1);

  typedef struct packed {
    logic              sign;
    cls_e              cls;
    rm_e               rmode;
    logic [EXP_W-1:0]  exp_f;
    logic [MANT_W-1:0] frac;
    logic              inc;
    logic              inx;
    logic              den;
    logic              ovf;
  } s1_t;

  logic s1_valid_q, s2_valid_q, s1_adv;
  s1_t  s1_d, s1_q;

  logic [WIDTH-1:0] res_d, res_q;
  logic [2:0]       flags_d, flags_q;

  logic             denorm;
  logic [AMT_W-1:0] amt;
  logic [SH_W-1:0]  sh;
  logic [MW-1:0]    mant_sh;
  logic             sh_lost;
  logic             unused_hidden;

  logic [EXP_W+MANT_W-1:0] sum;
  logic                    ovf;

  // Handshake: each stage advances when the one after it is empty or draining.
  always_comb begin
    s1_adv   = !s2_valid_q | out_ready;
    in_ready = !s1_valid_q | s1_adv;
  end

  // Stage 1 shift amount: 1-in_exp for non-positive exponents, capped.
  always_comb begin
    denorm = ($signed(in_exp) <= 0);
    amt    = AMT_W'(1) - {in_exp[EXP_W+1], in_exp};
    sh     = '0;
    if (denorm) sh = (amt > SH_SAT) ? SH_W'(MW - 1) : amt[SH_W-1:0];
  end

  rshift_sticky #(
    .W    (MW),
    .SH_W (SH_W)
  ) u_rshift (
    .in_i     (in_mant),
    .sh_i     (sh),
    .out_o    (mant_sh),
    .sticky_o (sh_lost)
  );

  assign unused_hidden = mant_sh[MW-1];

  // Stage 1 payload: round bits and increment decision for the shifted significand.
  always_comb begin
    s1_d       = '0;
    s1_d.sign  = in_sign;
    s1_d.cls   = cls_e'(in_class);
    s1_d.rmode = rm_e'(rm);
    s1_d.exp_f = denorm ? '0 : in_exp[EXP_W-1:0];
    s1_d.frac  = mant_sh[MW-2:3];
    s1_d.inx   = mant_sh[2] | mant_sh[1] | mant_sh[0] | sh_lost;
    s1_d.inc   = round_inc(rm_e'(rm), in_sign, mant_sh[3], mant_sh[2],
                           mant_sh[1] | mant_sh[0] | sh_lost);
    s1_d.den   = denorm;
    s1_d.ovf   = !denorm && ($signed(in_exp) >= $signed({2'b00, EXP_ONES}));
  end

  // Stage 2: increment lands on {exp,frac} so fraction carry bumps the exponent.
  always_comb begin
    sum     = {s1_q.exp_f, s1_q.frac} + (EXP_W + MANT_W)'(s1_q.inc);
    ovf     = s1_q.ovf | (sum[EXP_W+MANT_W-1:MANT_W] == EXP_ONES);
    res_d   = '0;
    flags_d = '0;
    case (s1_q.cls)
      CLS_NAN:  res_d = {1'b0, EXP_ONES, QNAN_FRAC};
      CLS_INF:  res_d = {s1_q.sign, EXP_ONES, {MANT_W{1'b0}}};
      CLS_ZERO: res_d = {s1_q.sign, {EXP_W{1'b0}}, {MANT_W{1'b0}}};
      default: begin
        if (!ovf)                                res_d = {s1_q.sign, sum};
        else if (ovf_to_inf(s1_q.rmode, s1_q.sign)) res_d = {s1_q.sign, EXP_ONES, {MANT_W{1'b0}}};
        else                                     res_d = {s1_q.sign, EXP_MAXF, {MANT_W{1'b1}}};
        flags_d[FLG_OVF] = ovf;
        flags_d[FLG_UNF] = s1_q.inx & s1_q.den;
        flags_d[FLG_INX] = s1_q.inx | ovf;
      end
    endcase
  end

  // Pipeline registers; async reset drops in-flight beats and clears the output word.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_q       <= '0;
      res_q      <= '0;
      flags_q    <= '0;
    end else begin
      if (in_ready)             s1_valid_q <= in_valid;
      if (in_valid && in_ready) s1_q       <= s1_d;
      if (s1_adv)               s2_valid_q <= s1_valid_q;
      if (s1_valid_q && s1_adv) begin
        res_q   <= res_d;
        flags_q <= flags_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign res       = res_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_real_round.sv
module tb_real_round;

  logic        clk, reset;
  logic        in_valid, in_ready, in_sign;
  logic [12:0] in_exp;
  logic [55:0] in_mant;
  logic [1:0]  in_class, rm;
  logic        out_valid, out_ready;
  logic [63:0] res;
  logic [2:0]  flags;

  int errors = 0;
  int checks = 0;

  localparam logic [55:0] M_ONE   = 56'h80_0000_0000_0000;
  localparam logic [55:0] M_CARRY = 56'hFF_FFFF_FFFF_FFFC;

  real_round #(.EXP_W(11), .MANT_RAW_W(53), .WIDTH(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant), .in_class(in_class),
    .rm(rm), .out_valid(out_valid), .out_ready(out_ready), .res(res), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: value = M * 2^(e-bias-55); quantise to the IEEE grid with integer division.
  function automatic void model(input logic s, input logic [12:0] e, input logic [55:0] m,
                                input logic [1:0] c, input logic [1:0] r,
                                output logic [63:0] res_e, output logic [2:0] flg_e);
    int ei, k, ef;
    longint unsigned mm, tr, rem, half, q;
    logic up, inx, den, to_inf;
    ei     = int'($signed(e));
    res_e  = '0;
    flg_e  = '0;
    to_inf = (r == 2'd0) || (r == 2'd2 && !s) || (r == 2'd3 && s);
    if (c == 2'd3)      res_e = {1'b0, 11'h7FF, 1'b1, 51'h0};
    else if (c == 2'd2) res_e = {s, 11'h7FF, 52'h0};
    else if (c == 2'd1) res_e = {s, 63'h0};
    else if (ei >= 2047) begin
      res_e = to_inf ? {s, 11'h7FF, 52'h0} : {s, 11'h7FE, {52{1'b1}}};
      flg_e = 3'b101;
    end else begin
      mm   = 64'(m);
      den  = (ei <= 0);
      k    = den ? 4 - ei : 3;
      if (k > 63) k = 63;
      tr   = mm >> k;
      rem  = mm - (tr << k);
      half = 64'd1 << (k - 1);
      case (r)
        2'd0:    up = (rem > half) || (rem == half && tr[0]);
        2'd1:    up = 1'b0;
        2'd2:    up = !s && rem != 0;
        default: up = s && rem != 0;
      endcase
      q   = tr + (up ? 64'd1 : 64'd0);
      inx = (rem != 0);
      if (den) ef = (q >= (64'd1 << 52)) ? 1 : 0;
      else begin
        ef = ei;
        if (q == (64'd1 << 53)) begin ef = ei + 1; q = 64'd1 << 52; end
      end
      if (ef >= 2047) begin
        res_e = to_inf ? {s, 11'h7FF, 52'h0} : {s, 11'h7FE, {52{1'b1}}};
        flg_e = 3'b101;
      end else begin
        res_e = {s, 11'(ef), q[51:0]};
        flg_e = {1'b0, den && inx, inx};
      end
    end
  endfunction

  task automatic rand_beat(output logic s, output logic [12:0] e, output logic [55:0] m,
                           output logic [1:0] c, output logic [1:0] r);
    int sel;
    s   = 1'($urandom_range(0, 1));
    r   = 2'($urandom_range(0, 3));
    c   = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
    sel = int'($urandom_range(0, 9));
    if (sel <= 4)      e = 13'($urandom_range(1, 2046));
    else if (sel == 5) e = 13'($urandom_range(2040, 2046));
    else if (sel <= 7) e = 13'(-int'($urandom_range(0, 60)));
    else if (sel == 8) e = 13'($urandom_range(2047, 2100));
    else               e = 13'(-int'($urandom_range(61, 4000)));
    m     = 56'({$urandom, $urandom});
    m[55] = 1'b1;
    if ($urandom_range(0, 5) == 0) m[54:3] = '1;
  endtask

  // Single beat with out_ready high; returns the result and the cycles from presentation.
  task automatic send_one(input logic s, input logic [12:0] e, input logic [55:0] m,
                          input logic [1:0] c, input logic [1:0] r,
                          output logic [63:0] rr, output logic [2:0] ff, output int lat);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_sign = s; in_exp = e; in_mant = m; in_class = c; rm = r;
    out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 10) begin @(negedge clk); #1; n++; end
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1; rr = '0; ff = '0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (out_valid) begin lat = k; rr = res; ff = flags; break; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_sign = 1'b0; in_exp = '0; in_mant = '0; in_class = '0; rm = '0;
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL reset_res: got %h exp 0", res); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b exp 000", flags); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", in_ready); end
    reset = 1'b1;
  endtask

  typedef struct {
    int          e;
    logic        s;
    logic [55:0] m;
    logic [1:0]  r;
    logic [63:0] res;
    logic [2:0]  fl;
  } dv_t;

  task automatic test_directed();
    dv_t tv[11];
    logic [63:0] rr; logic [2:0] ff; int lat;
    tv[0]  = '{1023, 1'b0, M_ONE,   2'd0, 64'h3FF0000000000000, 3'b000};
    tv[1]  = '{1023, 1'b0, M_CARRY, 2'd0, 64'h4000000000000000, 3'b001};
    tv[2]  = '{1023, 1'b0, M_CARRY, 2'd1, 64'h3FFFFFFFFFFFFFFF, 3'b001};
    tv[3]  = '{2047, 1'b0, M_ONE,   2'd0, 64'h7FF0000000000000, 3'b101};
    tv[4]  = '{2047, 1'b0, M_ONE,   2'd1, 64'h7FEFFFFFFFFFFFFF, 3'b101};
    tv[5]  = '{2047, 1'b1, M_ONE,   2'd2, 64'hFFEFFFFFFFFFFFFF, 3'b101};
    tv[6]  = '{0,    1'b0, M_ONE,   2'd0, 64'h0008000000000000, 3'b000};
    tv[7]  = '{-60,  1'b0, M_ONE,   2'd0, 64'h0000000000000000, 3'b011};
    tv[8]  = '{-60,  1'b0, M_ONE,   2'd2, 64'h0000000000000001, 3'b011};
    tv[9]  = '{2046, 1'b0, M_CARRY, 2'd0, 64'h7FF0000000000000, 3'b101};
    tv[10] = '{0,    1'b0, M_CARRY, 2'd0, 64'h0010000000000000, 3'b011};
    foreach (tv[i]) begin
      send_one(tv[i].s, 13'(tv[i].e), tv[i].m, 2'b00, tv[i].r, rr, ff, lat);
      checks++; if (lat !== 2) begin errors++; $display("FAIL dir%0d_latency: got %0d exp 2", i, lat); end
      checks++; if (rr !== tv[i].res) begin errors++; $display("FAIL dir%0d_res: got %h exp %h", i, rr, tv[i].res); end
      checks++; if (ff !== tv[i].fl) begin errors++; $display("FAIL dir%0d_flags: got %b exp %b", i, ff, tv[i].fl); end
    end
  endtask

  task automatic test_backpressure();
    logic s[4]; logic [12:0] e[4]; logic [55:0] m[4]; logic [1:0] c[4], r[4];
    logic [63:0] er[4]; logic [2:0] ef[4];
    logic [63:0] held; logic have_held;
    int sent, got, acc_at_drop;
    for (int i = 0; i < 4; i++) begin
      rand_beat(s[i], e[i], m[i], c[i], r[i]);
      c[i] = 2'b00;
      model(s[i], e[i], m[i], c[i], r[i], er[i], ef[i]);
    end
    sent = 0; got = 0; acc_at_drop = -1; have_held = 1'b0; held = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 5);
      in_valid  = (sent < 4);
      if (sent < 4) begin
        in_sign = s[sent]; in_exp = e[sent]; in_mant = m[sent]; in_class = c[sent]; rm = r[sent];
      end
      #1;
      if (out_valid && !out_ready) begin
        if (have_held) begin
          checks++; if (res !== held) begin errors++; $display("FAIL bp_stable: got %h exp %h", res, held); end
        end else begin held = res; have_held = 1'b1; end
      end
      if (out_valid && out_ready && got < 4) begin
        checks++; if (res !== er[got]) begin errors++; $display("FAIL bp_res%0d: got %h exp %h", got, res, er[got]); end
        checks++; if (flags !== ef[got]) begin errors++; $display("FAIL bp_flags%0d: got %b exp %b", got, flags, ef[got]); end
        got++;
      end
      if (in_valid && !in_ready && acc_at_drop < 0) acc_at_drop = sent;
      if (in_valid && in_ready) sent++;
      if (got == 4) break;
    end
    in_valid = 1'b0;
    checks++; if (got !== 4) begin errors++; $display("FAIL bp_count: got %0d exp 4", got); end
    checks++; if (acc_at_drop !== 2) begin errors++; $display("FAIL bp_in_ready_drop: got %0d exp 2", acc_at_drop); end
  endtask

  task automatic test_specials();
    logic [63:0] rr, er; logic [2:0] ff, ef; int lat;
    logic s; logic [12:0] e; logic [55:0] m; logic [1:0] c, r;
    for (int cl = 1; cl <= 3; cl++) begin
      for (int mode = 0; mode < 4; mode++) begin
        rand_beat(s, e, m, c, r);
        model(s, e, m, 2'(cl), 2'(mode), er, ef);
        send_one(s, e, m, 2'(cl), 2'(mode), rr, ff, lat);
        checks++; if (rr !== er) begin errors++; $display("FAIL special_c%0d_rm%0d_res: got %h exp %h", cl, mode, rr, er); end
        checks++; if (ff !== 3'b000) begin errors++; $display("FAIL special_c%0d_rm%0d_flags: got %b exp 000", cl, mode, ff); end
      end
    end
  endtask

  task automatic test_random();
    logic [66:0] q[$];
    logic [66:0] exp_e;
    logic [63:0] er; logic [2:0] ef;
    logic s; logic [12:0] e; logic [55:0] m; logic [1:0] c, r;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      rand_beat(s, e, m, c, r);
      in_valid = ($urandom_range(0, 9) < 7);
      in_sign = s; in_exp = e; in_mant = m; in_class = c; rm = r;
      out_ready = ($urandom_range(0, 9) < 7);
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++; $display("FAIL rnd_spurious: got %h exp none", res);
        end else begin
          exp_e = q.pop_front();
          checks++;
          if ({res, flags} !== exp_e) begin
            errors++; $display("FAIL rnd_beat: got %h/%b exp %h/%b", res, flags, exp_e[66:3], exp_e[2:0]);
          end
        end
      end
      if (in_valid && in_ready) begin
        model(s, e, m, c, r, er, ef);
        q.push_back({er, ef});
      end
    end
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0; out_ready = 1'b1;
      #1;
      if (out_valid && q.size() > 0) begin
        exp_e = q.pop_front();
        checks++;
        if ({res, flags} !== exp_e) begin
          errors++; $display("FAIL rnd_drain: got %h/%b exp %h/%b", res, flags, exp_e[66:3], exp_e[2:0]);
        end
      end
      if (q.size() == 0) break;
    end
    checks++; if (q.size() != 0) begin errors++; $display("FAIL rnd_leftover: got %0d exp 0", q.size()); end
  endtask

  task automatic test_reset_midburst();
    logic [63:0] rr, er; logic [2:0] ff, ef; int lat;
    logic s; logic [12:0] e; logic [55:0] m; logic [1:0] c, r;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rand_beat(s, e, m, c, r);
      in_valid = 1'b1; in_sign = s; in_exp = 13'd1000; in_mant = m; in_class = 2'b00; rm = r;
      out_ready = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid: got %b exp 1", out_valid); end
    #1 reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_out_valid: got %b exp 0", out_valid); end
    checks++; if (res !== 64'h0) begin errors++; $display("FAIL mid_res: got %h exp 0", res); end
    checks++; if (flags !== 3'b000) begin errors++; $display("FAIL mid_flags: got %b exp 000", flags); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rand_beat(s, e, m, c, r);
    model(s, 13'd1500, m, 2'b00, r, er, ef);
    send_one(s, 13'd1500, m, 2'b00, r, rr, ff, lat);
    checks++; if (lat !== 2) begin errors++; $display("FAIL post_rst_latency: got %0d exp 2", lat); end
    checks++; if (rr !== er) begin errors++; $display("FAIL post_rst_res: got %h exp %h", rr, er); end
    checks++; if (ff !== ef) begin errors++; $display("FAIL post_rst_flags: got %b exp %b", ff, ef); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_specials();
    test_random();
    test_reset_midburst();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
